// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding and FSM states.
// The controller imports the same op constants when it issues MDU operations.
package mdu_pkg;

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  function automatic logic is_muldiv(input logic [2:0] op);
    return op <= OP_DIV;
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iteration datapath: radix-2 shift-add multiply or restoring divide, one step per cycle.
// Operands arrive as unsigned magnitudes; sign handling lives in the parent.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_mode_div,
  input  logic [WIDTH-1:0]     i_a_mag,
  input  logic [WIDTH-1:0]     i_b_mag,
  output logic [2*WIDTH-1:0]   o_acc,
  output logic [WIDTH-1:0]     o_rem
);

  logic                 r_mode_div;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH:0]       r_rem;

  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH+1:0]     w_div_diff;

  // Multiply: multiplier sits in the low half of r_acc and shifts out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  // Divide: the low half of r_acc holds the dividend, replaced bit by bit with quotient bits.
  assign w_div_diff = {r_rem, r_acc[WIDTH-1]} - {2'b00, r_opnd};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_div <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
    end else if (i_load) begin
      r_mode_div <= i_mode_div;
      r_opnd     <= i_mode_div ? i_b_mag : i_a_mag;
      r_acc      <= {{WIDTH{1'b0}}, (i_mode_div ? i_a_mag : i_b_mag)};
      r_rem      <= '0;
    end else if (i_step) begin
      if (r_mode_div) begin
        if (!w_div_diff[WIDTH+1]) begin
          r_rem              <= w_div_diff[WIDTH:0];
          r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b1};
        end else begin
          r_rem              <= {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
          r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
      end
    end
  end

  assign o_acc = r_acc;
  assign o_rem = r_rem[WIDTH-1:0];

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
//   state | meaning
//   IDLE  | accepts start; MTHI/MTLO complete here in one cycle
//   RUN   | one mul/div iteration per cycle, counter counts down to 0
//   FIX   | sign correction, HI/LO write, done pulse follows
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t           r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_div, r_neg_lo, r_neg_hi, r_dbz_pend;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_done, r_dbz;

  logic                 w_accept, w_start_md, w_step, w_fix, w_busy;
  logic                 w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0]   w_acc, w_prod;
  logic [WIDTH-1:0]     w_rem_mag, w_quo, w_rem;

  assign w_accept   = start && (r_state == ST_IDLE);
  assign w_start_md = w_accept && is_muldiv(op);

  assign w_a_neg = is_signed_op(op) && a[WIDTH-1];
  assign w_b_neg = is_signed_op(op) && b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_md)   w_next = ST_RUN;
      ST_RUN:  if (r_cnt == '0)  w_next = ST_FIX;
      ST_FIX:                    w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      ST_RUN:  begin w_busy = 1'b1; w_step = 1'b1; end
      ST_FIX:  begin w_busy = 1'b1; w_fix  = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div      <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_a        <= '0;
    end else if (w_start_md) begin
      r_cnt      <= CW'(WIDTH-1);
      r_div      <= op[1];
      r_neg_lo   <= w_a_neg ^ w_b_neg;
      r_neg_hi   <= w_a_neg;
      r_dbz_pend <= op[1] && (b == '0);
      r_a        <= a;
    end else if (w_step) begin
      r_cnt      <= r_cnt - 1'b1;
    end
  end

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_start_md),
    .i_step     (w_step),
    .i_mode_div (op[1]),
    .i_a_mag    (w_a_mag),
    .i_b_mag    (w_b_mag),
    .o_acc      (w_acc),
    .o_rem      (w_rem_mag)
  );

  // MIN / -1 needs no special case: the negated magnitude wraps back to MIN.
  assign w_prod = r_neg_lo ? -w_acc : w_acc;
  assign w_quo  = r_neg_lo ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
  assign w_rem  = r_neg_hi ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      if (w_accept && op == OP_MTHI) begin
        r_hi   <= a;
        r_done <= 1'b1;
      end else if (w_accept && op == OP_MTLO) begin
        r_lo   <= a;
        r_done <= 1'b1;
      end else if (w_fix) begin
        r_done <= 1'b1;
        r_dbz  <= r_dbz_pend;
        if (r_dbz_pend) begin
          r_hi <= r_a;
          r_lo <= '1;
        end else if (r_div) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end else begin
          {r_hi, r_lo} <= w_prod;
        end
      end
    end
  end

  assign busy        = w_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo at WIDTH=32.
module tb_mdu_hilo;

  localparam logic [2:0] MULTU = 3'd0, MULT = 3'd1, DIVU = 3'd2, DIV = 3'd3,
                         MTHI  = 3'd4, MTLO = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Issue one op and wait (bounded) for done; lat counts edges after the sampling edge.
  task automatic go(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                    output int lat, output int bcnt, output bit to);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = busy ? 1 : 0; to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin to = 1'b0; break; end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({hi, lo} !== 64'h0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dbz=%b, want all zero", hi, lo, busy, done, div_by_zero);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_multu;
    int lat, bcnt; bit to;
    go(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, to);
    n_vec++;
    if (to || lat != 33) begin n_err++; $display("FAIL multu_latency: got %0d timeout=%0b, want 33", lat, to); end
    n_vec++;
    if (bcnt != 33) begin n_err++; $display("FAIL multu_busy_cycles: got %0d, want 33", bcnt); end
    n_vec++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL multu_result: hi=%h lo=%h busy=%b dbz=%b, want fffffffe 00000001 0 0", hi, lo, busy, div_by_zero);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse: done=%b one cycle later, want 0", done); end
  endtask

  task automatic test_signed;
    int lat, bcnt; bit to;
    go(MULT, 32'hFFFF_FFFD, 32'd5, lat, bcnt, to);
    n_vec++;
    if (to || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      n_err++; $display("FAIL mult_neg: hi=%h lo=%h to=%0b, want ffffffff fffffff1", hi, lo, to);
    end
    go(DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt, to);
    n_vec++;
    if (to || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL div_neg: lo=%h hi=%h dbz=%b, want fffffffd ffffffff 0", lo, hi, div_by_zero);
    end
    go(DIVU, 32'd7, 32'd2, lat, bcnt, to);
    n_vec++;
    if (to || lat != 33 || lo !== 32'd3 || hi !== 32'd1) begin
      n_err++; $display("FAIL divu: lo=%h hi=%h lat=%0d, want 3 1 33", lo, hi, lat);
    end
    go(MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, lat, bcnt, to);
    n_vec++;
    if (to || hi !== 32'h0 || lo !== 32'd6) begin
      n_err++; $display("FAIL mult_negneg: hi=%h lo=%h, want 0 6", hi, lo);
    end
  endtask

  task automatic test_div_zero;
    int lat, bcnt; bit to;
    go(DIVU, 32'd5, 32'd0, lat, bcnt, to);
    n_vec++;
    if (to || lat != 33 || hi !== 32'd5 || lo !== 32'hFFFF_FFFF || div_by_zero !== 1'b1) begin
      n_err++; $display("FAIL divu_zero: hi=%h lo=%h dbz=%b lat=%0d, want 5 ffffffff 1 33", hi, lo, div_by_zero, lat);
    end
    @(posedge clk); #1;
    n_vec++;
    if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dbz_pulse: dbz=%b next cycle, want 0", div_by_zero); end
    go(DIV, 32'hFFFF_FFF9, 32'd0, lat, bcnt, to);
    n_vec++;
    if (to || hi !== 32'hFFFF_FFF9 || lo !== 32'hFFFF_FFFF || div_by_zero !== 1'b1) begin
      n_err++; $display("FAIL div_zero_signed: hi=%h lo=%h dbz=%b, want fffffff9 ffffffff 1", hi, lo, div_by_zero);
    end
  endtask

  task automatic test_overflow;
    int lat, bcnt; bit to;
    go(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, to);
    n_vec++;
    if (to || lo !== 32'h8000_0000 || hi !== 32'h0 || div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL div_overflow: lo=%h hi=%h dbz=%b, want 80000000 0 0", lo, hi, div_by_zero);
    end
  endtask

  task automatic test_mthi_mtlo;
    int ndone = 0; bit saw_busy = 0;
    @(negedge clk);
    start = 1'b1; op = MTHI; a = 32'h1234; b = '0;
    @(posedge clk); #1;
    if (done) ndone++;
    if (busy) saw_busy = 1;
    op = MTLO; a = 32'hABCD;
    @(posedge clk); #1;
    start = 1'b0;
    if (done) ndone++;
    if (busy) saw_busy = 1;
    n_vec++;
    if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi: hi=%h, want 00001234", hi); end
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (busy) saw_busy = 1;
    end
    n_vec++;
    if (lo !== 32'hABCD || hi !== 32'h1234) begin n_err++; $display("FAIL mtlo: hi=%h lo=%h, want 00001234 0000abcd", hi, lo); end
    n_vec++;
    if (ndone != 2 || saw_busy) begin n_err++; $display("FAIL mt_done_busy: dones=%0d busy_seen=%0b, want 2 0", ndone, saw_busy); end
  endtask

  task automatic test_back_to_back;
    int cyc = 0; bit to = 1;
    @(negedge clk);
    start = 1'b1; op = MULTU; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin to = 0; break; end
      if (cyc == 9)  begin start = 1'b1; op = DIVU; a = 32'd50; b = 32'd5; end
      if (cyc == 10) begin op = MTLO; a = 32'hDEAD; end
      if (cyc == 11) start = 1'b0;
    end
    n_vec++;
    if (to || cyc != 33 || hi !== 32'h0 || lo !== 32'd6) begin
      n_err++; $display("FAIL ignored_start: hi=%h lo=%h lat=%0d, want 0 6 33", hi, lo, cyc);
    end
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: busy=%b, want 1", busy); end
    cyc = 0; to = 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin to = 0; break; end
    end
    n_vec++;
    if (to || cyc != 33 || lo !== 32'd14 || hi !== 32'd2) begin
      n_err++; $display("FAIL b2b_result: lo=%h hi=%h lat=%0d, want e 2 33", lo, hi, cyc);
    end
  endtask

  task automatic test_reset_mid_op;
    int ndone = 0, lat, bcnt; bit to;
    @(negedge clk);
    start = 1'b1; op = MULT; a = 32'hFFFF_FFFD; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: hi=%h lo=%h busy=%b, want 0 0 0", hi, lo, busy);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_vec++;
    if (ndone != 0) begin n_err++; $display("FAIL reset_no_done: dones=%0d, want 0", ndone); end
    go(MULTU, 32'd4, 32'd4, lat, bcnt, to);
    n_vec++;
    if (to || lo !== 32'd16 || hi !== 32'h0) begin
      n_err++; $display("FAIL after_reset: hi=%h lo=%h, want 0 10", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with its own architectural HI/LO registers, parametrised in operand width. It replaces single-cycle HI/LO handling in the MIPS core with a multi-cycle shift-add / restoring-divide engine. The engine exposes a start/busy/done handshake so the controller can stall on MFHI/MFLO. It sits beside the ALU in the datapath: the controller issues MULT/MULTU/DIV/DIVU/MTHI/MTLO, and the datapath reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  MULTU=0, MULT=1, DIVU=2, DIV=3, MTHI=4, MTLO=5; codes 6 and 7 are ignored (no response).
- `a`  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `busy`  out  1  high while a multiply or divide is in flight.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated.
- `div_by_zero`  out  1  pulses with `done` when a DIV/DIVU had `b`=0.
- `hi`  out  WIDTH  architectural HI register.
- `lo`  out  WIDTH  architectural LO register.

## Operation
- Reset values:
  - `hi`=0, `lo`=0.
  - `busy`=0, `done`=0, `div_by_zero`=0.
  - FSM in IDLE.
- FSM states are IDLE, RUN and FIX.
- **IDLE, `start` with MUL/DIV op:**
  - Latch operands. For signed ops, latch the magnitudes |a| and |b| and record the result signs.
  - Load counter = WIDTH-1, set `busy`, go to RUN.
- **IDLE, `start` with MTHI/MTLO:**
  - Write `a` into `hi` or `lo` at that edge and pulse `done` the next cycle.
  - `busy` never asserts. The FSM stays in IDLE.
- **RUN:** perform one iteration per cycle.
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract; the remainder register is WIDTH+1 bits.
  - Counter decrements each cycle. At counter=0, go to FIX.
- **FIX:** apply sign correction and write `hi`/`lo`. Register `done`=1 and `busy`=0 for the following cycle, then return to IDLE.
- **Multiply result:** {HI,LO} = full 2·WIDTH-bit product. For MULT the product is two's-complement negated when the operand signs differ.
- **Divide result:** LO = quotient, HI = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- **Divide by zero** (DIV/DIVU with `b`=0):
  - HI = `a` unchanged, LO = all ones.
  - `div_by_zero` pulses with `done`.
  - Full latency still applies.
- **Signed overflow** (DIV with MIN / −1): LO = MIN, HI = 0, no flag.
- `hi`/`lo` hold their old values for the whole of RUN. MFHI/MFLO during `busy` return stale data, so the controller must stall.
- `start` while `busy`=1 is ignored for all ops, including MTHI/MTLO. Nothing is queued.
- `rst` during RUN/FIX aborts the operation: HI/LO are cleared and no `done` is produced.

## Timing
- Count the edge that samples `start` as E0. For MUL/DIV:
  - `busy`=1 after E0.
  - RUN occupies edges E1..E(WIDTH).
  - FIX occurs at E(WIDTH+1).
  - After E(WIDTH+1), `hi`/`lo` are valid, `done`=1 and `busy`=0.
- Latency from `start` to `done` is WIDTH+1 cycles, i.e. 33 for WIDTH=32.
- MTHI/MTLO latency is 1 cycle.
- A new `start` is accepted in the same cycle that `done` is high, giving back-to-back issue at WIDTH+1 cycles per operation.
- `done` and `div_by_zero` are registered outputs with no combinational path from the inputs.

## Structure
- Package `mdu_pkg` holds:
  - the `op` encoding constants,
  - the FSM state enum (IDLE/RUN/FIX).
- The `mips` controlunit imports the same op constants.
- One sub-module, `mdu_iter`, holds the iteration datapath:
  - accumulator/remainder registers and the per-cycle add/subtract-shift step,
  - a mode input selecting mul or div.
- `mdu_hilo` holds the FSM, the counter, the sign handling, and the HI/LO registers.

## Test plan
All scenarios use WIDTH=32.
- **MULTU:** `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → `done` at 33 cycles; HI=0xFFFFFFFE, LO=0x00000001; `busy` high for exactly the 33 cycles before `done`.
- **MULT:** −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. **DIV:** −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. **DIVU:** 7 / 2 → LO=3, HI=1.
- **DIVU by zero:** 5 / 0 → HI=5, LO=0xFFFFFFFF, `div_by_zero`=1 for one cycle together with `done`. **DIV overflow:** 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, no flag.
- **MTHI/MTLO:** MTHI 0x1234 then MTLO 0xABCD on consecutive cycles → HI=0x1234, LO=0xABCD, one `done` per op, `busy` never high.
- **Ignored start:** issue MULTU 2×3; at cycle 10 issue DIVU and MTLO → both ignored; result HI=0, LO=6; then issue DIVU in the `done` cycle → accepted.
- **Reset mid-op:** assert `rst` at cycle 15 of a MULT → HI=LO=0, `busy`=0, no `done` pulse; the next MULTU 4×4 gives LO=16.
